enc_frame_sched: RTL and testbench

// - Shares one 4-state Mealy bit encoder (ports clk, din, op; no reset) among NREQ frame requesters.
// - Round-robin picks a requester, serializes its frame MSB-first onto enc_din and returns the encoded bits with owner id.
// - Because the encoder has no reset, this block keeps a shadow copy of the encoder state.
// - After every rst, and after every frame, it drives din bits that put the encoder back in S0.

---
 rtl/enc_sched_pkg.sv | 47 ++++
 rtl/enc_frame_sched_rr_arbiter.sv | 29 ++
 rtl/enc_frame_sched.sv | 144 ++++++++++++++
 tb/tb_enc_frame_sched.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enc_sched_pkg.sv
// Shared types and helpers for the encoder frame scheduler: encoder/control
// state encodings, the sync word and the encoder next-state model.
package enc_sched_pkg;

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } enc_state_t;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        IDLE  = 2'd1,
        SEND  = 2'd2,
        FLUSH = 2'd3
    } ctrl_state_t;

    localparam int SYNC_LEN = 7;
    // Drives the encoder to S0 from any start state, sent MSB first.
    localparam logic [SYNC_LEN-1:0] SYNC_WORD = 7'b0011001;

    function automatic enc_state_t enc_next(input enc_state_t state, input logic din);
        enc_state_t nxt;
        case (state)
            S0:      nxt = din ? S1 : S0;
            S1:      nxt = din ? S1 : S2;
            S2:      nxt = din ? S2 : S3;
            S3:      nxt = din ? S0 : S3;
            default: nxt = S0;
        endcase
        return nxt;
    endfunction

    // Number of flush bits (zeros then a final one) that return a state to S0.
    function automatic logic [1:0] flush_len(input enc_state_t state);
        logic [1:0] len;
        case (state)
            S1:      len = 2'd3;
            S2:      len = 2'd2;
            S3:      len = 2'd1;
            default: len = 2'd0;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/enc_frame_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant for the first set request at or after ptr.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] gnt,
    output logic [ID_W-1:0] idx
);

    logic found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int off = 0; off < NREQ; off++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && req[i] && (((int'(ptr) + off) % NREQ) == i)) begin
                    found  = 1'b1;
                    gnt[i] = 1'b1;
                    idx    = ID_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/enc_frame_sched.sv
// Shares one reset-less Mealy bit encoder among NREQ requesters; tracks the
// encoder state in a shadow copy and flushes it back to S0 after each frame.
module enc_frame_sched
    import enc_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int FRAME_W = 8,
    parameter int ID_W    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*FRAME_W-1:0] data,
    output logic [NREQ-1:0]         gnt,
    output logic                    enc_din,
    input  logic                    enc_op,
    output logic                    out_bit,
    output logic                    out_valid,
    output logic                    out_last,
    output logic [ID_W-1:0]         out_id
);

    localparam int CNT_W = ($clog2(FRAME_W) > 3) ? $clog2(FRAME_W) : 3;

    ctrl_state_t        state, state_n;
    enc_state_t         shadow, shadow_n, shadow_step;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [FRAME_W-1:0] shreg, shreg_n;
    logic [ID_W-1:0]    ptr, ptr_n, owner, owner_n, id_n;
    logic               din_n, bit_n, valid_n, last_n;
    logic [NREQ-1:0]    arb_gnt;
    logic [ID_W-1:0]    arb_idx;
    logic [FRAME_W-1:0] frames [NREQ];
    logic [2:0]         sync_idx;

    rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
        .req (req),
        .ptr (ptr),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    always_comb begin
        for (int i = 0; i < NREQ; i++) frames[i] = data[i*FRAME_W +: FRAME_W];
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_n     = state;
        cnt_n       = cnt;
        shreg_n     = shreg;
        shadow_n    = shadow;
        ptr_n       = ptr;
        owner_n     = owner;
        din_n       = 1'b0;
        bit_n       = 1'b0;
        valid_n     = 1'b0;
        last_n      = 1'b0;
        id_n        = '0;
        gnt         = '0;
        shadow_step = enc_next(shadow, enc_din);
        sync_idx    = 3'(SYNC_LEN - 2) - cnt[2:0];

        case (state)
            SYNC: begin
                if (cnt == CNT_W'(SYNC_LEN - 1)) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                    din_n = SYNC_WORD[sync_idx];
                end
            end
            IDLE: begin
                if (req != '0) begin
                    if (!rst) gnt = arb_gnt;
                    owner_n = arb_idx;
                    ptr_n   = ID_W'((int'(arb_idx) + 1) % NREQ);
                    din_n   = frames[arb_idx][FRAME_W-1];
                    shreg_n = {frames[arb_idx][FRAME_W-2:0], 1'b0};
                    cnt_n   = '0;
                    state_n = SEND;
                end
            end
            SEND: begin
                shadow_n = shadow_step;
                bit_n    = enc_op;
                valid_n  = 1'b1;
                id_n     = owner;
                if (cnt == CNT_W'(FRAME_W - 1)) begin
                    last_n = 1'b1;
                    cnt_n  = '0;
                    if (shadow_step == S0) begin
                        state_n = IDLE;
                    end else begin
                        state_n = FLUSH;
                        din_n   = (flush_len(shadow_step) == 2'd1);
                    end
                end else begin
                    cnt_n   = cnt + CNT_W'(1);
                    din_n   = shreg[FRAME_W-1];
                    shreg_n = {shreg[FRAME_W-2:0], 1'b0};
                end
            end
            FLUSH: begin
                // The remaining flush length of the stepped state selects the final 1.
                shadow_n = shadow_step;
                if (shadow_step == S0) state_n = IDLE;
                else                   din_n   = (flush_len(shadow_step) == 2'd1);
            end
            default: state_n = SYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SYNC;
            cnt       <= '0;
            shreg     <= '0;
            shadow    <= S0;
            ptr       <= '0;
            owner     <= '0;
            enc_din   <= 1'b0;
            out_bit   <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_id    <= '0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            state     <= state_n;
            cnt       <= cnt_n;
            shreg     <= shreg_n;
            shadow    <= shadow_n;
            ptr       <= ptr_n;
            owner     <= owner_n;
            enc_din   <= din_n;
            out_bit   <= bit_n;
            out_valid <= valid_n;
            out_last  <= last_n;
            out_id    <= id_n;
        end
    end

endmodule

// File: tb/tb_enc_frame_sched.sv
// Self-checking bench for enc_frame_sched with a behavioural reset-less encoder
// and a scoreboard of expected encoded bits.
module tb_enc_frame_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = 4'b0;
    logic [31:0] data = 32'b0;
    logic [3:0]  gnt;
    logic        enc_din, enc_op, out_bit, out_valid, out_last;
    logic [1:0]  out_id;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int gnt_cyc = 0;

    typedef struct packed {
        logic       b;
        logic       last;
        logic [1:0] id;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;

    // Encoder powers up in an arbitrary state; S2 exercises the sync word.
    logic [1:0] enc_st = 2'd2;

    enc_frame_sched #(.NREQ(4), .FRAME_W(8), .ID_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .data      (data),
        .gnt       (gnt),
        .enc_din   (enc_din),
        .enc_op    (enc_op),
        .out_bit   (out_bit),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_id    (out_id)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [1:0] b_next(input logic [1:0] st, input logic din);
        case ({st, din})
            3'b00_0: return 2'd0;
            3'b00_1: return 2'd1;
            3'b01_0: return 2'd2;
            3'b01_1: return 2'd1;
            3'b10_0: return 2'd3;
            3'b10_1: return 2'd2;
            3'b11_0: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic b_op(input logic [1:0] st, input logic din);
        case ({st, din})
            3'b00_0: return 1'b0;
            3'b00_1: return 1'b1;
            3'b01_0: return 1'b0;
            3'b01_1: return 1'b1;
            3'b10_0: return 1'b1;
            3'b10_1: return 1'b0;
            3'b11_0: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    always_comb enc_op = b_op(enc_st, enc_din);
    always @(posedge clk) enc_st <= b_next(enc_st, enc_din);

    task automatic push_frame(input logic [3:0] g);
        logic [1:0] idx;
        logic [7:0] f;
        logic [1:0] st;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) if (g[i]) idx = 2'(i);
        f  = 8'(data >> (8 * idx));
        st = 2'd0;
        for (int k = 0; k < 8; k++) begin
            sb.push_back('{b: b_op(st, f[7]), last: (k == 7), id: idx});
            st = b_next(st, f[7]);
            f  = f << 1;
        end
    endtask

    // Scoreboard: expected bits pushed on each grant, popped on each valid output.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL out_unexpected: out_valid=1 bit=%b last=%b id=%0d, no bit pending",
                         out_bit, out_last, out_id);
            end else begin
                e_mon = sb.pop_front();
                if ({out_bit, out_last, out_id} !== e_mon) begin
                    n_err++;
                    $display("FAIL out_bit: got bit=%b last=%b id=%0d, expected bit=%b last=%b id=%0d",
                             out_bit, out_last, out_id, e_mon.b, e_mon.last, e_mon.id);
                end
            end
        end
        if (gnt !== 4'b0 && rst === 1'b0) push_frame(gnt);
    end

    task automatic check_sync(input string name);
        logic [6:0] sw;
        sw = 7'b0011001;
        for (int k = 0; k < 7; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
                @(negedge clk);
            end
            n_cmp++;
            if (enc_din !== sw[6] || gnt !== 4'b0 || out_valid !== 1'b0 || out_last !== 1'b0) begin
                n_err++;
                $display("FAIL %s[%0d]: enc_din=%b gnt=%b out_valid=%b out_last=%b, expected enc_din=%b gnt=0000 valid=0 last=0",
                         name, k, enc_din, gnt, out_valid, out_last, sw[6]);
            end
            sw = sw << 1;
        end
    endtask

    task automatic expect_grant(input string name, input logic [3:0] exp, input int max_cycles);
        int waited;
        waited = 1;
        while (gnt === 4'b0 && waited < max_cycles) begin
            @(posedge clk); #1;
            @(negedge clk);
            waited++;
        end
        gnt_cyc = cyc;
        n_cmp++;
        if (gnt !== exp) begin
            n_err++;
            $display("FAIL %s: gnt=%b expected %b after %0d cycles", name, gnt, exp, waited);
        end
    endtask

    // Called at the grant cycle; checks SEND bits, flush bits and the return to IDLE.
    task automatic follow_frame(input string name, input logic [7:0] frame, input logic [3:0] req_during);
        logic [7:0] f;
        logic [1:0] st;
        logic [2:0] fl;
        int         flen;
        f  = frame;
        st = 2'd0;
        @(posedge clk); #1;
        req = req_during;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            @(negedge clk);
            n_cmp++;
            if (enc_din !== f[7] || gnt !== 4'b0) begin
                n_err++;
                $display("FAIL %s_send[%0d]: enc_din=%b gnt=%b, expected enc_din=%b gnt=0000",
                         name, k, enc_din, gnt, f[7]);
            end
            st = b_next(st, f[7]);
            f  = f << 1;
        end
        case (st)
            2'd1:    begin flen = 3; fl = 3'b001; end
            2'd2:    begin flen = 2; fl = 3'b010; end
            2'd3:    begin flen = 1; fl = 3'b100; end
            default: begin flen = 0; fl = 3'b000; end
        endcase
        for (int j = 0; j < flen; j++) begin
            @(posedge clk); #1;
            @(negedge clk);
            n_cmp++;
            if (enc_din !== fl[2] || gnt !== 4'b0 || (j > 0 && out_valid !== 1'b0)) begin
                n_err++;
                $display("FAIL %s_flush[%0d]: enc_din=%b gnt=%b out_valid=%b, expected enc_din=%b gnt=0000",
                         name, j, enc_din, gnt, out_valid, fl[2]);
            end
            fl = fl << 1;
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if (enc_din !== 1'b0 || enc_st !== 2'd0) begin
            n_err++;
            $display("FAIL %s_idle: enc_din=%b encoder_state=%0d, expected enc_din=0 encoder_state=0",
                     name, enc_din, enc_st);
        end
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        req  = 4'b1111;
        data = 32'h0;
        @(negedge clk);
        n_cmp++;
        if ({gnt, enc_din, out_bit, out_valid, out_last, out_id} !== 10'b0) begin
            n_err++;
            $display("FAIL reset_outputs: gnt=%b enc_din=%b out_bit=%b out_valid=%b out_last=%b out_id=%0d, expected all 0",
                     gnt, enc_din, out_bit, out_valid, out_last, out_id);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_sync("reset_sync");
        @(posedge clk); #1;
        @(negedge clk);
        expect_grant("reset_first_gnt", 4'b0001, 1);
        follow_frame("reset_frame", 8'h00, 4'b0000);
    endtask

    task automatic test_single_frame();
        @(posedge clk); #1;
        req       = 4'b0001;
        data[7:0] = 8'hA5;
        @(negedge clk);
        expect_grant("single_gnt", 4'b0001, 3);
        follow_frame("single_a5", 8'hA5, 4'b0000);
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_g [5];
        int         prev;
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        prev  = 0;
        @(posedge clk); #1;
        rst  = 1'b1;
        req  = 4'b0000;
        data = 32'h0;
        @(posedge clk); #1;
        rst = 1'b0;
        req = 4'b1111;
        sb.delete();
        @(negedge clk);
        check_sync("b2b_sync");
        @(posedge clk); #1;
        @(negedge clk);
        for (int g = 0; g < 5; g++) begin
            expect_grant($sformatf("b2b_gnt%0d", g), exp_g[g], 1);
            if (g > 0) begin
                n_cmp++;
                if (gnt_cyc - prev != 9) begin
                    n_err++;
                    $display("FAIL b2b_spacing%0d: grants %0d cycles apart, expected 9", g, gnt_cyc - prev);
                end
            end
            prev = gnt_cyc;
            follow_frame($sformatf("b2b_frame%0d", g), 8'h00, (g == 4) ? 4'b0000 : 4'b1111);
        end
    endtask

    task automatic test_reset_mid_frame();
        @(posedge clk); #1;
        req         = 4'b0100;
        data[23:16] = 8'h3C;
        @(negedge clk);
        expect_grant("midrst_gnt", 4'b0100, 3);
        repeat (3) begin
            @(posedge clk); #1;
            @(negedge clk);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || out_last !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_drop: out_valid=%b out_last=%b, expected 0 0", out_valid, out_last);
        end
        check_sync("midrst_sync");
        @(posedge clk); #1;
        @(negedge clk);
        expect_grant("midrst_regnt", 4'b0100, 1);
        follow_frame("midrst_frame", 8'h3C, 4'b0000);
    endtask

    task automatic test_flush_recovery();
        @(posedge clk); #1;
        req        = 4'b0010;
        data[15:8] = 8'hFF;
        @(negedge clk);
        expect_grant("flush_gnt_ff", 4'b0010, 3);
        follow_frame("flush_ff", 8'hFF, 4'b0000);
        @(posedge clk); #1;
        req        = 4'b0010;
        data[15:8] = 8'hA5;
        @(negedge clk);
        expect_grant("flush_gnt_a5", 4'b0010, 3);
        follow_frame("flush_a5", 8'hA5, 4'b0000);
    endtask

    task automatic test_req_during_send();
        @(posedge clk); #1;
        req          = 4'b0001;
        data[7:0]    = 8'h00;
        data[31:24]  = 8'h5A;
        @(negedge clk);
        expect_grant("late_gnt0", 4'b0001, 3);
        follow_frame("late_frame0", 8'h00, 4'b1001);
        expect_grant("late_gnt3", 4'b1000, 1);
        follow_frame("late_frame3", 8'h5A, 4'b0001);
        expect_grant("late_gnt0_again", 4'b0001, 4);
        follow_frame("late_frame0_again", 8'h00, 4'b0000);
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_reset_mid_frame();
        test_flush_recovery();
        test_req_during_send();
        @(posedge clk); #1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d expected bits never produced, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
